agc_stat_engine: RTL and testbench

- Multi-channel, parametrised AGC measurement engine in the aclk domain, sitting between the RFDC ADC AXI4-Stream outputs and the wishbone register bank.
- Over a programmable number of valid beats, it accumulates the per-channel sum of squares, the count of samples above +threshold and the count of samples below −threshold.
- At the end of the run it latches the results into hold registers, which are read back through a registered channel-select port.
- It replaces the single-channel, fixed-131072-clock AGC timer and accumulator path. It adds abort, variable period, and valid-gated accumulation.

---
 rtl/agc_stat_engine.sv | 263 ++++++++++++++++++++++++++
 tb/tb_agc_stat_engine.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/agc_stat_engine.sv
// agc_stat_engine
//   Multi-channel AGC measurement engine (aclk domain). Over a programmed
//   number of accepted beats it accumulates, per channel, the sum of squares
//   of all samples and the counts of samples above +thresh / below -thresh,
//   then latches the totals into hold registers for registered readback.
//
// Ports
//   aclk, aresetn        clock, async active-low reset
//   adc_tdata/adc_tvalid ADC stream; channel c at [c*NSAMP*16 +: NSAMP*16],
//                        sample i of a channel at lane bits [16i+4 +: SAMP_BITS]
//   start_i, abort_i     single-cycle run request / cancel
//   period_i, thresh_i   beats per run and magnitude threshold (taken at start)
//   busy_o, done_o       run in progress / one-cycle result-update pulse
//   results_valid_o      sticky, set by the first completed run
//   rd_chan_i            readback channel select (>= NCHAN reads zeros)
//   rd_sq_o/gt_o/lt_o    held results of the selected channel, 1-cycle latency

// Per-lane stage 2: square and signed threshold compares, registered.
module agc_stat_lane #(
   parameter int SAMP_BITS = 12
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic [SAMP_BITS-1:0]     i_samp,
   input  logic [SAMP_BITS-2:0]     i_thresh,
   output logic [2*SAMP_BITS-1:0]   o_sq,
   output logic                     o_gt,
   output logic                     o_lt
);
   logic signed [2*SAMP_BITS-1:0] w_se;
   logic signed [2*SAMP_BITS-1:0] w_prod;
   logic signed [SAMP_BITS:0]     w_sx;
   logic signed [SAMP_BITS:0]     w_tp;
   logic signed [SAMP_BITS:0]     w_tn;

   // Full-width product so that the most negative sample squares exactly.
   assign w_se   = {{SAMP_BITS{i_samp[SAMP_BITS-1]}}, i_samp};
   assign w_prod = w_se * w_se;
   // One extra bit keeps -thresh representable for any threshold value.
   assign w_sx   = {i_samp[SAMP_BITS-1], i_samp};
   assign w_tp   = {2'b00, i_thresh};
   assign w_tn   = -w_tp;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         o_sq <= '0;
         o_gt <= 1'b0;
         o_lt <= 1'b0;
      end else begin
         o_sq <= w_prod;
         o_gt <= (w_sx > w_tp);
         o_lt <= (w_sx < w_tn);
      end
   end
endmodule

module agc_stat_engine #(
   parameter  int NCHAN       = 8,
   parameter  int NSAMP       = 8,
   parameter  int SAMP_BITS   = 12,
   parameter  int PERIOD_BITS = 20,
   localparam int NS_W        = $clog2(NSAMP),
   localparam int SQ_BITS     = 2*SAMP_BITS + NS_W + PERIOD_BITS,
   localparam int CNT_BITS    = NS_W + PERIOD_BITS + 1,
   localparam int RD_W        = $clog2(NCHAN) + 1
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic [NCHAN*NSAMP*16-1:0] adc_tdata,
   input  logic                      adc_tvalid,
   input  logic                      start_i,
   input  logic                      abort_i,
   input  logic [PERIOD_BITS-1:0]    period_i,
   input  logic [SAMP_BITS-2:0]      thresh_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      results_valid_o,
   input  logic [RD_W-1:0]           rd_chan_i,
   output logic [SQ_BITS-1:0]        rd_sq_o,
   output logic [CNT_BITS-1:0]       rd_gt_o,
   output logic [CNT_BITS-1:0]       rd_lt_o
);
   localparam int LANES  = NCHAN*NSAMP;
   localparam int PROD_W = 2*SAMP_BITS;
   localparam int SUM_W  = PROD_W + NS_W;
   localparam int PC_W   = NS_W + 1;
   localparam int CH_W   = (NCHAN > 1) ? $clog2(NCHAN) : 1;
   localparam logic [RD_W-1:0] NCHAN_RD = RD_W'(NCHAN);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_LATCH} state_t;

   state_t                    r_state, w_state_nxt;
   logic [PERIOD_BITS-1:0]    r_period, r_beat_cnt;
   logic [SAMP_BITS-2:0]      r_thresh;
   logic [1:0]                r_flush_cnt;
   logic                      w_start_ok, w_acc;
   logic [3:1]                r_vld_pipe;

   logic [LANES-1:0][SAMP_BITS-1:0] w_lane, r_s1_samp;
   logic [LANES-1:0][PROD_W-1:0]    w_s2_sq;
   logic [LANES-1:0]                w_s2_gt, w_s2_lt;
   logic [NCHAN-1:0][SUM_W-1:0]     w_s3_sq, r_s3_sq;
   logic [NCHAN-1:0][PC_W-1:0]      w_s3_gt, w_s3_lt, r_s3_gt, r_s3_lt;

   logic [NCHAN-1:0][SQ_BITS-1:0]   r_acc_sq, r_hold_sq;
   logic [NCHAN-1:0][CNT_BITS-1:0]  r_acc_gt, r_acc_lt, r_hold_gt, r_hold_lt;
   logic                            r_done, r_rv;

   // Abort has priority over a simultaneous start.
   assign w_start_ok = start_i && !abort_i && (r_state == S_IDLE);
   // Counter check precedes acceptance, so exactly P beats enter the pipe.
   assign w_acc      = adc_tvalid && (r_state == S_RUN) && (r_beat_cnt < r_period);

   //------------------------------------------------------------------ FSM
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_start_ok) w_state_nxt = S_RUN;
         S_RUN:   if (abort_i)                   w_state_nxt = S_IDLE;
                  else if (r_beat_cnt == r_period) w_state_nxt = S_FLUSH;
         // Three cycles cover stage 2, stage 3 and the accumulate.
         S_FLUSH: if (abort_i)                   w_state_nxt = S_IDLE;
                  else if (r_flush_cnt == 2'd2)  w_state_nxt = S_LATCH;
         S_LATCH: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_period    <= '0;
         r_thresh    <= '0;
         r_beat_cnt  <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_start_ok) begin
            r_period   <= period_i;
            r_thresh   <= thresh_i;
            r_beat_cnt <= '0;
         end else if (w_acc) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
         end
         r_flush_cnt <= (r_state == S_FLUSH) ? r_flush_cnt + 2'd1 : 2'd0;
      end
   end

   //------------------------------------------------------------ pipeline
   // Valid bits are cleared on start so leftovers of an aborted run
   // cannot leak into the freshly cleared accumulators.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)        r_vld_pipe <= '0;
      else if (w_start_ok) r_vld_pipe <= '0;
      else                 r_vld_pipe <= {r_vld_pipe[2:1], w_acc};
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign w_lane[l] = adc_tdata[l*16+4 +: SAMP_BITS];

      agc_stat_lane #(.SAMP_BITS(SAMP_BITS)) u_lane (
         .aclk     (aclk),
         .aresetn  (aresetn),
         .i_samp   (r_s1_samp[l]),
         .i_thresh (r_thresh),
         .o_sq     (w_s2_sq[l]),
         .o_gt     (w_s2_gt[l]),
         .o_lt     (w_s2_lt[l])
      );
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) r_s1_samp <= '0;
      else          r_s1_samp <= w_lane;
   end

   // Stage 3: per-channel sum of squares and flag popcounts.
   always_comb begin
      w_s3_sq = '0;
      w_s3_gt = '0;
      w_s3_lt = '0;
      for (int c = 0; c < NCHAN; c++) begin
         for (int i = 0; i < NSAMP; i++) begin
            w_s3_sq[c] = w_s3_sq[c] + SUM_W'(w_s2_sq[c*NSAMP+i]);
            w_s3_gt[c] = w_s3_gt[c] + PC_W'(w_s2_gt[c*NSAMP+i]);
            w_s3_lt[c] = w_s3_lt[c] + PC_W'(w_s2_lt[c*NSAMP+i]);
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_s3_sq <= '0;
         r_s3_gt <= '0;
         r_s3_lt <= '0;
      end else begin
         r_s3_sq <= w_s3_sq;
         r_s3_gt <= w_s3_gt;
         r_s3_lt <= w_s3_lt;
      end
   end

   //---------------------------------------------------- accumulate / hold
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_acc_sq <= '0;
         r_acc_gt <= '0;
         r_acc_lt <= '0;
      end else if (w_start_ok) begin
         r_acc_sq <= '0;
         r_acc_gt <= '0;
         r_acc_lt <= '0;
      end else if (r_vld_pipe[3] && (r_state == S_RUN || r_state == S_FLUSH)) begin
         for (int c = 0; c < NCHAN; c++) begin
            r_acc_sq[c] <= r_acc_sq[c] + SQ_BITS'(r_s3_sq[c]);
            r_acc_gt[c] <= r_acc_gt[c] + CNT_BITS'(r_s3_gt[c]);
            r_acc_lt[c] <= r_acc_lt[c] + CNT_BITS'(r_s3_lt[c]);
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_hold_sq <= '0;
         r_hold_gt <= '0;
         r_hold_lt <= '0;
         r_rv      <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= (r_state == S_LATCH);
         if (r_state == S_LATCH) begin
            r_hold_sq <= r_acc_sq;
            r_hold_gt <= r_acc_gt;
            r_hold_lt <= r_acc_lt;
            r_rv      <= 1'b1;
         end
      end
   end

   //------------------------------------------------------------- readback
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rd_sq_o <= '0;
         rd_gt_o <= '0;
         rd_lt_o <= '0;
      end else if (rd_chan_i < NCHAN_RD) begin
         rd_sq_o <= r_hold_sq[rd_chan_i[CH_W-1:0]];
         rd_gt_o <= r_hold_gt[rd_chan_i[CH_W-1:0]];
         rd_lt_o <= r_hold_lt[rd_chan_i[CH_W-1:0]];
      end else begin
         rd_sq_o <= '0;
         rd_gt_o <= '0;
         rd_lt_o <= '0;
      end
   end

   assign busy_o          = (r_state != S_IDLE);
   assign done_o          = r_done;
   assign results_valid_o = r_rv;
endmodule

// File: tb/tb_agc_stat_engine.sv
// Directed testbench for agc_stat_engine: hand-computed expected results
// for single-channel stimulus, latency, abort, async reset and readback.
module tb_agc_stat_engine;
   localparam int NCHAN = 8, NSAMP = 8, SAMP_BITS = 12, PERIOD_BITS = 20;
   localparam int SQ_BITS = 47, CNT_BITS = 24, RD_W = 4;

   logic                      aclk, aresetn;
   logic [NCHAN*NSAMP*16-1:0] adc_tdata;
   logic                      adc_tvalid, start_i, abort_i;
   logic [PERIOD_BITS-1:0]    period_i;
   logic [SAMP_BITS-2:0]      thresh_i;
   logic                      busy_o, done_o, results_valid_o;
   logic [RD_W-1:0]           rd_chan_i;
   logic [SQ_BITS-1:0]        rd_sq_o;
   logic [CNT_BITS-1:0]       rd_gt_o, rd_lt_o;

   int vecs = 0, errs = 0;
   int lat, nd;
   bit pv;

   agc_stat_engine #(.NCHAN(NCHAN), .NSAMP(NSAMP), .SAMP_BITS(SAMP_BITS),
                     .PERIOD_BITS(PERIOD_BITS)) dut (
      .aclk(aclk), .aresetn(aresetn), .adc_tdata(adc_tdata), .adc_tvalid(adc_tvalid),
      .start_i(start_i), .abort_i(abort_i), .period_i(period_i), .thresh_i(thresh_i),
      .busy_o(busy_o), .done_o(done_o), .results_valid_o(results_valid_o),
      .rd_chan_i(rd_chan_i), .rd_sq_o(rd_sq_o), .rd_gt_o(rd_gt_o), .rd_lt_o(rd_lt_o)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_chan(input int c, input int v);
      logic [11:0] s;
      s = v[11:0];
      for (int i = 0; i < NSAMP; i++) adc_tdata[c*NSAMP*16 + i*16 +: 16] = {s, 4'h5};
   endtask

   task automatic chk_chan(input string tag, input int c, input longint sq,
                           input int gt, input int lt);
      rd_chan_i = RD_W'(c);
      tick();
      chk({tag, "_sq"}, 64'(rd_sq_o), 64'(sq));
      chk({tag, "_gt"}, 64'(rd_gt_o), 64'(gt));
      chk({tag, "_lt"}, 64'(rd_lt_o), 64'(lt));
   endtask

   // Start a run and count cycles from the start-sampling edge to done_o.
   task automatic run(input int p, input int thr, input bit toggle,
                      output int l, output bit rv_before);
      bit prev;
      period_i   = PERIOD_BITS'(p);
      thresh_i   = (SAMP_BITS-1)'(thr);
      adc_tvalid = 1'b1;
      start_i    = 1'b1;
      tick();
      start_i = 1'b0;
      l = 0;
      prev = 1'b0;
      while (l < 300) begin
         if (toggle) adc_tvalid = ~adc_tvalid;
         prev = results_valid_o;
         tick();
         l++;
         if (done_o) break;
      end
      if (!done_o) l = -1;
      rv_before  = prev;
      adc_tvalid = 1'b1;
   endtask

   initial begin
      aresetn = 1'b0; adc_tdata = '0; adc_tvalid = 1'b0; start_i = 1'b0;
      abort_i = 1'b0; period_i = '0; thresh_i = '0; rd_chan_i = '0;
      repeat (3) @(posedge aclk);
      #1;
      chk("rst_busy", 64'(busy_o), 0);
      chk("rst_done", 64'(done_o), 0);
      chk("rst_rv",   64'(results_valid_o), 0);
      chk("rst_sq",   64'(rd_sq_o), 0);
      @(negedge aclk) aresetn = 1'b1;
      tick();

      // Channel 0 at +100, P=4, thresh=50.
      set_chan(0, 100);
      run(4, 50, 1'b0, lat, pv);
      chk("t1_lat", 64'(lat), 9);
      chk("t1_rv_before", 64'(pv), 0);
      chk("t1_rv_at_done", 64'(results_valid_o), 1);
      tick();
      chk("t1_done_pulse", 64'(done_o), 0);
      chk_chan("t1_c0", 0, 320000, 32, 0);
      chk_chan("t1_c1", 1, 0, 0, 0);
      chk_chan("t1_c7", 7, 0, 0, 0);
      rd_chan_i = 0;
      tick();
      rd_chan_i = RD_W'(NCHAN);
      chk("rd_latency_old", 64'(rd_sq_o), 320000);
      tick();
      chk("rd_oor_sq", 64'(rd_sq_o), 0);
      chk("rd_oor_gt", 64'(rd_gt_o), 0);

      // Channel 3 at -2048, thresh=2047, P=16.
      adc_tdata = '0;
      set_chan(3, -2048);
      run(16, 2047, 1'b0, lat, pv);
      chk("t2_lat", 64'(lat), 21);
      chk_chan("t2_c3", 3, 536870912, 0, 128);
      chk_chan("t2_c0", 0, 0, 0, 0);

      // Channel 1 at +100 with tvalid toggling, P=8.
      adc_tdata = '0;
      set_chan(1, 100);
      run(8, 50, 1'b1, lat, pv);
      chk("t3_lat", 64'(lat), 21);
      chk_chan("t3_c1", 1, 640000, 64, 0);

      // Abort mid-RUN with an ignored start while busy.
      set_chan(1, 200);
      period_i = 10; thresh_i = 50; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      tick(); tick();
      chk("ab_busy", 64'(busy_o), 1);
      start_i = 1'b1; tick(); start_i = 1'b0;
      tick();
      abort_i = 1'b1; tick(); abort_i = 1'b0;
      chk("ab_idle", 64'(busy_o), 0);
      nd = 0;
      for (int i = 0; i < 30; i++) begin tick(); if (done_o) nd++; end
      chk("ab_no_done", 64'(nd), 0);
      chk("ab_rv", 64'(results_valid_o), 1);
      chk_chan("ab_c1", 1, 640000, 64, 0);

      // Start plus abort together in IDLE: the start is dropped.
      start_i = 1'b1; abort_i = 1'b1; tick();
      start_i = 1'b0; abort_i = 1'b0;
      chk("sa_idle", 64'(busy_o), 0);
      nd = 0;
      for (int i = 0; i < 20; i++) begin tick(); if (done_o || busy_o) nd++; end
      chk("sa_quiet", 64'(nd), 0);

      // Start while busy must not restart the run or change the period.
      period_i = 4; thresh_i = 50; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      lat = 0;
      while (lat < 100) begin
         if (lat == 2) begin start_i = 1'b1; period_i = 10; end
         else start_i = 1'b0;
         tick();
         lat++;
         if (done_o) break;
      end
      start_i = 1'b0;
      chk("bs_lat", 64'(lat), 9);
      chk_chan("bs_c1", 1, 1280000, 32, 0);

      // Asynchronous reset in the middle of a run.
      period_i = 20; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      repeat (3) tick();
      chk("ar_busy_pre", 64'(busy_o), 1);
      #2 aresetn = 1'b0;
      #1;
      chk("ar_busy", 64'(busy_o), 0);
      chk("ar_done", 64'(done_o), 0);
      chk("ar_rv",   64'(results_valid_o), 0);
      chk("ar_sq",   64'(rd_sq_o), 0);
      chk("ar_gt",   64'(rd_gt_o), 0);
      @(negedge aclk) aresetn = 1'b1;
      repeat (5) tick();
      chk("ar_idle", 64'(busy_o), 0);

      // Zero-length run.
      set_chan(0, 300);
      run(0, 50, 1'b0, lat, pv);
      chk("p0_lat", 64'(lat), 5);
      chk("p0_rv", 64'(results_valid_o), 1);
      chk_chan("p0_c1", 1, 0, 0, 0);
      chk_chan("p0_c0", 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
